la_cgctrl: RTL and testbench
============================

# la_cgctrl

Clock-gate enable controller for the lambdalib stdlib. It watches a block's activity request and produces the registered enable `en`. That enable drives the D input of the transparent latch inside a clock-gating cell, directly upstream of that latch. The controller applies programmable idle hysteresis before gating, runs a fixed wake-up sequence with a `ready` indication before the clock is declared usable, and keeps a saturating gated-cycle counter for power statistics.

## Interface
- `PROP`, "DEFAULT", implementation property string, passed through untouched
- `CW`, 8, width of idle threshold and down-counter
- `WAKE_CYCLES`, 2, cycles between enable reassertion and `ready`; legal range 0..255
- `SW`, 16, width of gated-cycle statistics counter

Ports:
- `clk`  in  1  free-running (ungated) clock
- `nreset`  in  1  reset; asynchronous and active-low
- `req`  in  1  activity request; high means the gated domain needs clock
- `force`  in  1  force clock on (test/debug); same effect as `req`
- `idle_th`  in  CW  idle cycles tolerated before gating; sampled only on RUN->DRAIN
- `stat_clr`  in  1  synchronous clear of `gated_cnt`
- `en`  out  1  clock enable to latch D input, registered
- `ready`  out  1  gated domain clock is stable and usable, registered
- `state`  out  2  current FSM state, for status
- `gated_cnt`  out  SW  saturating count of cycles spent in OFF

## Operation
- `act` = `req` | `force`.
- FSM states and encodings:
  - RUN=0: `en`=1, `ready`=1.
  - DRAIN=1: `en`=1, `ready`=1.
  - OFF=2: `en`=0, `ready`=0.
  - WAKE=3: `en`=1, `ready`=0.
- RUN:
  - `act`=0 and `idle_th`=0 -> OFF.
  - `act`=0 and `idle_th`!=0 -> DRAIN, with `cnt` <= `idle_th`.
  - Otherwise stay in RUN.
- DRAIN:
  - `act`=1 -> RUN. This abort has priority.
  - `cnt`==1 -> OFF.
  - Otherwise `cnt` <= `cnt`-1.
- OFF:
  - `act`=1 and `WAKE_CYCLES`=0 -> RUN.
  - `act`=1 and `WAKE_CYCLES`!=0 -> WAKE, with `wcnt` <= `WAKE_CYCLES`.
- WAKE:
  - A drop of `act` during WAKE is ignored; the wake always completes.
  - `wcnt`==1 -> RUN.
  - Otherwise `wcnt`-1.
- `en` and `ready` are registered decodes of the next state, so they change on the same edge as `state`. There are no glitches, and `en` is stable across the latch's transparent phase.
- `gated_cnt`:
  - Increments by 1 each cycle `state`==OFF and saturates at 2^SW-1.
  - `stat_clr` has priority over increment.
  - Clear and increment in the same cycle yields 0.
- Changes to `idle_th` while in DRAIN have no effect until the next RUN->DRAIN.

## Timing
- Reset (async assert, sync-released by the integrator):
  - `state`=RUN, `en`=1, `ready`=1, `cnt`=0, `wcnt`=0, `gated_cnt`=0.
  - The clock runs during and after reset.
- Reset asserted mid-DRAIN/OFF/WAKE: `en` goes to 1 immediately (asynchronously).
- Gate latency: if `act`=0 is first sampled at edge k with `idle_th`=N, `en` falls after edge k+N, provided `act` stays 0. N=0 gives edge k.
- Wake latency: if `act`=1 is sampled in OFF at edge m, `en` rises after edge m. `ready` rises after edge m+`WAKE_CYCLES`.
- `act` pulse of one cycle in DRAIN: returns to RUN, then DRAIN restarts with a full `idle_th` reload.
- `act` pulse of one cycle in OFF: the full wake runs, then RUN, then DRAIN.

## Structure
- Package `la_cgctrl_pkg` holds:
  - state encodings RUN/DRAIN/OFF/WAKE as 2-bit localparams
  - the `state` port width constant
- Sub-module `la_satcnt` (parameter W; inputs `inc`, `clr`; output `q`): generic saturating counter with async active-low reset, instantiated for `gated_cnt`.
- The downstream clock-gate cell (latch + AND) is not part of this block.

## Test plan
- Reset then `act`=0, `idle_th`=3: `en` falls exactly 3 edges after first sample; `state` goes RUN->DRAIN->OFF; `ready`=0 with `en`.
- In OFF, `req`=1 with `WAKE_CYCLES`=2: `en`=1 after the next edge, `ready`=1 two edges later, `state` ends in RUN.
- `idle_th`=0 and `WAKE_CYCLES`=0: single-edge RUN<->OFF transitions; DRAIN and WAKE are never visited.
- Single-cycle `req` pulse at DRAIN `cnt`=1: returns to RUN and `en` never drops. Then `force`=1 alone holds RUN indefinitely.
- Hold OFF 70000 cycles with SW=16: `gated_cnt`=65535 and stays there. `stat_clr` with OFF active: `gated_cnt`=0 on that edge, 1 on the following.
- Assert `nreset` mid-WAKE and mid-OFF: `en`=1 and `ready`=1 asynchronously, `gated_cnt`=0. After release, `state`=RUN.

Source files
------------

// File: rtl/la_cgctrl_pkg.sv
// Shared types for the clock-gate enable controller.
package la_cgctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OFF   = 2'd2,
        ST_WAKE  = 2'd3
    } cg_state_e;

endpackage

// File: rtl/la_satcnt.sv
// Generic saturating up-counter with synchronous clear (clear wins over increment).
module la_satcnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         nreset_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (inc_i && (q_q != '1)) begin
            q_d = q_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/la_cgctrl.sv
// Clock-gate enable controller: idle hysteresis, fixed wake sequence with ready,
// and a saturating count of gated cycles.
module la_cgctrl
    import la_cgctrl_pkg::*;
#(
    parameter              PROP        = "DEFAULT",
    parameter int unsigned CW          = 8,
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned SW          = 16
) (
    input  logic               clk_i,
    input  logic               nreset_i,
    input  logic               req_i,
    input  logic               force_i,
    input  logic [CW-1:0]      idle_th_i,
    input  logic               stat_clr_i,
    output logic               en_o,
    output logic               ready_o,
    output logic [STATE_W-1:0] state_o,
    output logic [SW-1:0]      gated_cnt_o
);

    localparam logic [7:0] WAKE_LD = 8'(WAKE_CYCLES);

    cg_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    wcnt_q, wcnt_d;
    logic          en_q, en_d;
    logic          ready_q, ready_d;
    logic          act;

    if (PROP == "DEFAULT") begin : g_prop_default
    end

    assign act = req_i | force_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (!act) begin
                    if (idle_th_i == '0) begin
                        state_d = ST_OFF;
                    end else begin
                        state_d = ST_DRAIN;
                        cnt_d   = idle_th_i;
                    end
                end
            end
            ST_DRAIN: begin
                if (act) begin
                    state_d = ST_RUN;
                end else if (cnt_q == CW'(1)) begin
                    state_d = ST_OFF;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_OFF: begin
                if (act) begin
                    if (WAKE_LD == 8'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_WAKE;
                        wcnt_d  = WAKE_LD;
                    end
                end
            end
            ST_WAKE: begin
                // act is deliberately ignored: a started wake always completes
                if (wcnt_q == 8'd1) begin
                    state_d = ST_RUN;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
        en_d    = (state_d != ST_OFF);
        ready_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    end

    // en/ready are decoded from the next state so they flip on the same edge as state
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            en_q    <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            en_q    <= en_d;
            ready_q <= ready_d;
        end
    end

    la_satcnt #(
        .W(SW)
    ) u_gated_cnt (
        .clk_i    (clk_i),
        .nreset_i (nreset_i),
        .inc_i    (state_q == ST_OFF),
        .clr_i    (stat_clr_i),
        .q_o      (gated_cnt_o)
    );

    assign en_o    = en_q;
    assign ready_o = ready_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_la_cgctrl.sv
// Bench for la_cgctrl: two instances (wake 2 and wake 0) against a behavioural model.
module tb_la_cgctrl;

    logic        clk = 1'b0;
    logic        nreset;
    logic        req;
    logic        frc;
    logic        stat_clr;
    logic [7:0]  idle_th;
    logic        en    [2];
    logic        ready [2];
    logic [1:0]  state [2];
    logic [15:0] gated [2];
    bit          armed = 1'b0;

    int checks = 0;
    int passed = 0;

    // model: phase 0 run, 1 drain, 2 off, 3 wake
    int m_ph [2] = '{0, 0};
    int m_idle_left [2] = '{0, 0};
    int m_wake_left [2] = '{0, 0};
    int m_gc [2] = '{0, 0};

    always #5 clk = ~clk;

    la_cgctrl #(.CW(8), .WAKE_CYCLES(2), .SW(16)) u0 (
        .clk_i(clk), .nreset_i(nreset), .req_i(req), .force_i(frc),
        .idle_th_i(idle_th), .stat_clr_i(stat_clr),
        .en_o(en[0]), .ready_o(ready[0]), .state_o(state[0]), .gated_cnt_o(gated[0])
    );

    la_cgctrl #(.CW(8), .WAKE_CYCLES(0), .SW(16)) u1 (
        .clk_i(clk), .nreset_i(nreset), .req_i(req), .force_i(frc),
        .idle_th_i(idle_th), .stat_clr_i(stat_clr),
        .en_o(en[1]), .ready_o(ready[1]), .state_o(state[1]), .gated_cnt_o(gated[1])
    );

    function automatic int wake_len(int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < 2; i++) begin
                m_ph[i] <= 0;
                m_idle_left[i] <= 0;
                m_wake_left[i] <= 0;
                m_gc[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int ph, il, wl;
                bit busy;
                busy = req | frc;
                ph = m_ph[i];
                il = m_idle_left[i];
                wl = m_wake_left[i];
                if (ph == 0 && !busy) begin
                    il = int'(idle_th);
                    ph = (il == 0) ? 2 : 1;
                end else if (ph == 1) begin
                    if (busy) ph = 0;
                    else begin
                        il = il - 1;
                        if (il == 0) ph = 2;
                    end
                end else if (ph == 2 && busy) begin
                    wl = wake_len(i);
                    ph = (wl == 0) ? 0 : 3;
                end else if (ph == 3) begin
                    wl = wl - 1;
                    if (wl == 0) ph = 0;
                end
                m_ph[i] <= ph;
                m_idle_left[i] <= il;
                m_wake_left[i] <= wl;
                if (stat_clr) m_gc[i] <= 0;
                else if (m_ph[i] == 2) m_gc[i] <= (m_gc[i] >= 65535) ? 65535 : m_gc[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                int exp_v, act_v;
                exp_v = ((m_ph[i] != 2) ? (1 << 19) : 0) | ((m_ph[i] < 2) ? (1 << 18) : 0)
                      | (m_ph[i] << 16) | m_gc[i];
                act_v = (int'(en[i]) << 19) | (int'(ready[i]) << 18) | (int'(state[i]) << 16)
                      | int'(gated[i]);
                chk($sformatf("cycle_u%0d", i), act_v, exp_v);
            end
        end
    end

    initial begin
        nreset = 1'b1; req = 1'b1; frc = 1'b0; stat_clr = 1'b0; idle_th = 8'd3;
        #2 nreset = 1'b0;
        step(3);
        nreset = 1'b1;
        armed = 1'b1;
        chk("rst_state", int'(state[0]), 0);
        chk("rst_en", int'(en[0]), 1);
        chk("rst_ready", int'(ready[0]), 1);
        chk("rst_gated", int'(gated[0]), 0);

        // gate latency with idle_th=3
        req = 1'b0;
        step(1); chk("drain_k", int'(state[0]), 1);
        step(1); chk("drain_k1_en", int'(en[0]), 1);
        step(1); chk("drain_k2", int'(state[0]), 1);
        step(1);
        chk("off_state", int'(state[0]), 2);
        chk("off_en", int'(en[0]), 0);
        chk("off_ready", int'(ready[0]), 0);

        // wake latency
        req = 1'b1;
        step(1);
        chk("wake_en", int'(en[0]), 1);
        chk("wake_ready", int'(ready[0]), 0);
        chk("wake0_state", int'(state[1]), 0);
        chk("wake0_ready", int'(ready[1]), 1);
        step(1); chk("wake_ready_mid", int'(ready[0]), 0);
        step(1);
        chk("wake_done_ready", int'(ready[0]), 1);
        chk("wake_done_state", int'(state[0]), 0);

        // idle_th=0: single edge transitions
        idle_th = 8'd0; req = 1'b0;
        step(1);
        chk("fast_off_u0", int'(state[0]), 2);
        chk("fast_off_u1", int'(state[1]), 2);
        req = 1'b1;
        step(1);
        chk("fast_on_u1", int'(state[1]), 0);
        chk("fast_on_u0", int'(state[0]), 3);
        step(2);

        // pulse at cnt=1 aborts drain, then force holds RUN
        idle_th = 8'd3; req = 1'b0;
        step(3);
        chk("pulse_pre", int'(state[0]), 1);
        req = 1'b1;
        step(1);
        chk("pulse_run", int'(state[0]), 0);
        chk("pulse_en", int'(en[0]), 1);
        req = 1'b0; frc = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(1);
            chk("force_hold", int'(state[0]), 0);
        end
        frc = 1'b0;

        // saturation of the gated-cycle counter
        idle_th = 8'd0;
        step(66000);
        chk("sat_u0", int'(gated[0]), 65535);
        chk("sat_u1", int'(gated[1]), 65535);
        step(10);
        chk("sat_hold", int'(gated[0]), 65535);
        stat_clr = 1'b1;
        step(1);
        chk("clr_zero", int'(gated[0]), 0);
        stat_clr = 1'b0;
        step(1);
        chk("clr_next", int'(gated[0]), 1);

        // async reset mid-OFF
        nreset = 1'b0;
        #1;
        chk("arst_off_en", int'(en[0]), 1);
        chk("arst_off_ready", int'(ready[0]), 1);
        chk("arst_off_gated", int'(gated[0]), 0);
        step(2);
        nreset = 1'b1;
        step(1);
        chk("arst_off_after", int'(state[0]), 2);
        req = 1'b1;
        step(1);
        chk("pre_arst_wake", int'(state[0]), 3);
        nreset = 1'b0;
        #1;
        chk("arst_wake_en", int'(en[0]), 1);
        chk("arst_wake_ready", int'(ready[0]), 1);
        chk("arst_wake_gated", int'(gated[0]), 0);
        step(1);
        nreset = 1'b1;
        step(1);
        chk("arst_wake_after", int'(state[0]), 0);

        // randomized phase
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 99) < 15) req = ~req;
            frc      = ($urandom_range(0, 59) == 0);
            stat_clr = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) == 0) idle_th = 8'($urandom_range(0, 4));
            nreset   = ($urandom_range(0, 499) != 0);
            step(1);
        end
        nreset = 1'b1;
        step(2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
